// File: rtl/shift_add_multiplier_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
// Imported by the top and the bench so both agree on the state encoding.
package shift_add_multiplier_pkg;

  localparam int MULT_W = 4;
  localparam int CNT_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Product width follows the operand width.
  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Request/result bundle for the multiplier: operands and start in, busy/done/product out.
// start is a level request accepted on any edge where the block is IDLE or DONE; done is a one-cycle pulse.
interface shift_add_multiplier_if #(
  parameter int WIDTH = 4
) ();
  logic                   start;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     product;

  modport master (
    output start, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/shift_add_multiplier_fourbitadder.sv
// Four-bit ripple-carry adder; port index 1 is the MSB and index 4 the LSB.
// Purely combinational, used as the partial-sum datapath of the multiplier.
module fourbitadder (
  input  logic a1,
  input  logic a2,
  input  logic a3,
  input  logic a4,
  input  logic b1,
  input  logic b2,
  input  logic b3,
  input  logic b4,
  input  logic cin,
  output logic s1,
  output logic s2,
  output logic s3,
  output logic s4,
  output logic c
);

  logic c4;
  logic c3;
  logic c2;

  // Ripple from the LSB (index 4) toward the MSB (index 1).
  always_comb begin
    s4 = a4 ^ b4 ^ cin;
    c4 = (a4 & b4) | (a4 & cin) | (b4 & cin);
    s3 = a3 ^ b3 ^ c4;
    c3 = (a3 & b3) | (a3 & c4) | (b3 & c4);
    s2 = a2 ^ b2 ^ c3;
    c2 = (a2 & b2) | (a2 & c3) | (b2 & c3);
    s1 = a1 ^ b1 ^ c2;
    c  = (a1 & b1) | (a1 & c2) | (b1 & c2);
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential 4x4 unsigned multiplier: one multiplier bit per clock, shift-and-add
// through a single fourbitadder, with start/busy/done handoff and a registered product.
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH = MULT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  shift_add_multiplier_if.slave   mif,
  output state_e                  dbg_state
);

  if (WIDTH != 4) begin : g_width_check
    $error("shift_add_multiplier: WIDTH must be 4 (datapath is fourbitadder)");
  end

  localparam int PW = prod_w(MULT_W);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [MULT_W-1:0]  acc_q, acc_d;
  logic [MULT_W-1:0]  mq_q, mq_d;
  logic [MULT_W-1:0]  mcand_q, mcand_d;
  logic [PW-1:0]      product_q, product_d;

  logic [MULT_W-1:0]  add_s;
  logic               add_c;
  logic [MULT_W:0]    partial;
  logic [PW:0]        shifted;

  fourbitadder u_adder (
    .a1  (acc_q[3]),
    .a2  (acc_q[2]),
    .a3  (acc_q[1]),
    .a4  (acc_q[0]),
    .b1  (mcand_q[3]),
    .b2  (mcand_q[2]),
    .b3  (mcand_q[1]),
    .b4  (mcand_q[0]),
    .cin (1'b0),
    .s1  (add_s[3]),
    .s2  (add_s[2]),
    .s3  (add_s[1]),
    .s4  (add_s[0]),
    .c   (add_c)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mq_d      = mq_q;
    mcand_d   = mcand_q;
    product_d = product_q;

    // Carry-out is kept as bit 4 so it shifts into acc[3].
    partial = mq_q[0] ? {add_c, add_s} : {1'b0, acc_q};
    shifted = {partial, mq_q} >> 1;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (mif.start) begin
          mcand_d = mif.a;
          mq_d    = mif.b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_d = shifted[PW-1:MULT_W];
        mq_d  = shifted[MULT_W-1:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(MULT_W - 1)) begin
          state_d   = ST_DONE;
          product_d = shifted[PW-1:0];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mq_q      <= '0;
      mcand_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      mcand_q   <= mcand_d;
      product_q <= product_d;
    end
  end

  // All outputs are decodes of registered state, so there is no input-to-output path.
  assign mif.busy    = (state_q == ST_RUN);
  assign mif.done    = (state_q == ST_DONE);
  assign mif.product = product_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench: directed scenarios with literal products plus randomized traffic,
// all compared every cycle against a transaction-level model of the multiplier.
module tb_shift_add_multiplier;
  import shift_add_multiplier_pkg::*;

  logic   clk;
  logic   rst;
  state_e dbg_state;

  shift_add_multiplier_if #(.WIDTH(4)) mif ();

  shift_add_multiplier #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .mif       (mif),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompare = 0;
  bit check_en   = 1'b0;

  // ---------------- behavioural model ----------------
  logic [7:0] exp_q[$];
  bit         m_running = 1'b0;
  int         m_left    = 0;
  bit         m_done    = 1'b0;
  logic [7:0] m_product = 8'h00;

  always @(posedge clk) begin
    if (rst) begin
      m_running = 1'b0;
      m_left    = 0;
      m_done    = 1'b0;
      m_product = 8'h00;
      exp_q.delete();
    end else if (!m_running) begin
      m_done = 1'b0;
      if (mif.start) begin
        exp_q.push_back(8'(mif.a * mif.b));
        m_running = 1'b1;
        m_left    = 4;
      end
    end else begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_running = 1'b0;
        m_done    = 1'b1;
        m_product = exp_q.pop_front();
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompare++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clk) begin
    if (check_en) begin
      check("busy",    int'(mif.busy),    int'(m_running));
      check("done",    int'(mif.done),    int'(m_done));
      check("product", int'(mif.product), int'(m_product));
      check("busy_done_exclusive", int'(mif.busy & mif.done), 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits (at negedges) for done; returns number of negedges waited, or -1 on timeout.
  task automatic wait_done(input int budget, output int waited);
    waited = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (mif.done) begin
        waited = i;
        break;
      end
    end
    if (waited < 0) begin
      vectors++;
      miscompare++;
      $display("FAIL wait_done: got timeout expected done within %0d cycles", budget);
    end
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [7:0] lit,
                        input string name);
    int waited;
    int busy_cycles;
    mif.a = a; mif.b = b; mif.start = 1'b1;
    @(negedge clk);
    mif.start = 1'b0;
    busy_cycles = mif.busy ? 1 : 0;
    waited = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (mif.done) begin
        waited = i;
        break;
      end
      if (mif.busy) busy_cycles++;
    end
    if (waited < 0) begin
      vectors++;
      miscompare++;
      $display("FAIL %s_timeout: got no done expected done", name);
    end else begin
      check({name, "_product"}, int'(mif.product), int'(lit));
      check({name, "_busy_cycles"}, busy_cycles, 4);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int waited;
    int saw_done;
    rst = 1'b1;
    mif.start = 1'b0;
    mif.a = '0;
    mif.b = '0;

    // 1. reset for two cycles
    do_reset(2);
    check_en = 1'b1;
    check("reset_busy",    int'(mif.busy),    0);
    check("reset_done",    int'(mif.done),    0);
    check("reset_product", int'(mif.product), 8'h00);
    check("reset_state",   int'(dbg_state),   int'(ST_IDLE));

    // 2-4. directed products with literal results
    run_op(4'd3,  4'd5,  8'h0F, "mul_3x5");
    run_op(4'd15, 4'd15, 8'hE1, "mul_15x15");
    run_op(4'd0,  4'd9,  8'h00, "mul_0x9");
    run_op(4'd9,  4'd0,  8'h00, "mul_9x0");
    run_op(4'd12, 4'd11, 8'h84, "mul_12x11");

    // 5. start held high; operands changed mid-RUN; DONE-cycle start accepted
    @(negedge clk);
    mif.a = 4'd2; mif.b = 4'd3; mif.start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mif.a = 4'd4; mif.b = 4'd5;
    wait_done(10, waited);
    check("held_first_product", int'(mif.product), 8'h06);
    @(negedge clk);
    mif.start = 1'b0;
    check("held_reaccept_busy", int'(mif.busy), 1);
    wait_done(10, waited);
    check("held_second_product", int'(mif.product), 8'h14);

    // 6. reset in the middle of RUN aborts without a done pulse
    @(negedge clk);
    mif.a = 4'd7; mif.b = 4'd6; mif.start = 1'b1;
    @(negedge clk);
    mif.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 6; i++) begin
      if (mif.done) saw_done = 1;
      @(negedge clk);
    end
    check("abort_no_done",  saw_done,           0);
    check("abort_product",  int'(mif.product),  8'h00);
    check("abort_state",    int'(dbg_state),    int'(ST_IDLE));
    run_op(4'd7, 4'd6, 8'h2A, "mul_7x6_after_abort");

    // Randomized traffic: start toggles freely, including during RUN
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      mif.start = ($urandom_range(0, 2) != 0);
      mif.a     = 4'($urandom_range(0, 15));
      mif.b     = 4'($urandom_range(0, 15));
    end
    @(negedge clk);
    mif.start = 1'b0;
    repeat (8) @(negedge clk);

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompare);
    $finish;
  end

  // Absolute time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before %0t", $time);
    $fatal(1, "simulation time limit reached");
  end

endmodule
